weight_loader: RTL



---
 rtl/weight_loader_pkg.sv | 20 ++
 rtl/weight_loader_if.sv | 37 +++
 rtl/wl_hdr_decode.sv | 26 ++
 rtl/weight_loader.sv | 92 +++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
// Shared types for the weight loader: FSM states and header field layout.
// Header word: [15:12] layer ID, [11:0] neuron index.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    HDR,
    LOAD,
    SKIP,
    DONE
  } state_e;

  localparam int HDR_LAYER_MSB  = 15;
  localparam int HDR_LAYER_LSB  = 12;
  localparam int HDR_NEURON_MSB = 11;
  localparam int HDR_NEURON_LSB = 0;

  localparam int HDR_LAYER_W  = HDR_LAYER_MSB - HDR_LAYER_LSB + 1;
  localparam int HDR_NEURON_W = HDR_NEURON_MSB - HDR_NEURON_LSB + 1;

endpackage

// File: rtl/weight_loader_if.sv
// Weight stream in (s_valid/s_ready/s_data) and neuron memory write port out.
// slave: the loader side; master: the stream source / memory bank side.
interface weight_loader_if #(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 5,
  parameter int numNeuron    = 30
);

  logic                    s_valid;
  logic                    s_ready;
  logic [dataWidth-1:0]    s_data;
  logic                    wen;
  logic [addressWidth-1:0] wadd;
  logic [dataWidth-1:0]    win;
  logic [numNeuron-1:0]    wsel;

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output wen,
    output wadd,
    output win,
    output wsel
  );

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  wen,
    input  wadd,
    input  win,
    input  wsel
  );

endinterface

// File: rtl/wl_hdr_decode.sv
// Header decode: accept when layer matches and neuron index is in range.
// Ports: hdr in, accept out, idx out (neuron index, truncated).
module wl_hdr_decode
  import weight_loader_pkg::*;
#(
  parameter int numNeuron = 30,
  parameter int layerNum  = 2,
  parameter int IW        = $clog2(numNeuron)
) (
  input  logic [15:0]   hdr,
  output logic          accept,
  output logic [IW-1:0] idx
);

  logic [HDR_LAYER_W-1:0]  lyr;
  logic [HDR_NEURON_W-1:0] nrn;

  assign lyr = hdr[HDR_LAYER_MSB:HDR_LAYER_LSB];
  assign nrn = hdr[HDR_NEURON_MSB:HDR_NEURON_LSB];

  // full 12-bit compare, so indices beyond IW bits are rejected
  assign accept = (lyr == HDR_LAYER_W'(layerNum))
                && (nrn < HDR_NEURON_W'(numNeuron));
  assign idx = nrn[IW-1:0];

endmodule

// File: rtl/weight_loader.sv
// Streams header-tagged weight packets into per-neuron weight memories.
// Ports: clk, rst_n, s (stream + write port), busy, done, err pulses.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16,
  parameter int numNeuron    = 30,
  parameter int layerNum     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  weight_loader_if.slave  s,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int IW = $clog2(numNeuron);
  localparam logic [numNeuron-1:0] ONE = 1;
  localparam logic [addressWidth-1:0] LAST =
    addressWidth'(numWeight - 1);

  state_e                  state, nxt;
  logic [addressWidth-1:0] cnt;
  logic [IW-1:0]           idx_q, hidx;
  logic                    acc, fire, last, wr;

  wl_hdr_decode #(
    .numNeuron(numNeuron),
    .layerNum (layerNum),
    .IW       (IW)
  ) u_dec (
    .hdr   (s.s_data[15:0]),
    .accept(acc),
    .idx   (hidx)
  );

  // held low during reset, and for the single DONE cycle
  assign s.s_ready = rst_n & (state != DONE);
  assign fire      = s.s_valid & s.s_ready;
  assign last      = (cnt == LAST);
  assign wr        = fire & (state == LOAD);
  assign busy      = (state == LOAD) | (state == SKIP);
  assign done      = (state == DONE);

  always_comb begin
    nxt = state;
    unique case (state)
      HDR:       if (fire) nxt = acc ? LOAD : SKIP;
      LOAD, SKIP: if (fire && last) nxt = DONE;
      DONE:      nxt = HDR;
      default:   nxt = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HDR;
      cnt   <= '0;
      idx_q <= '0;
    end else begin
      state <= nxt;
      if (fire && state == HDR) begin
        cnt   <= '0;
        idx_q <= hidx;
      end else if (fire) begin
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.wen  <= 1'b0;
      s.wadd <= '0;
      s.win  <= '0;
      s.wsel <= '0;
      err    <= 1'b0;
    end else begin
      s.wen  <= wr;
      s.wsel <= wr ? (ONE << idx_q) : '0;
      if (wr) begin
        s.wadd <= cnt;
        s.win  <= s.s_data;
      end
      err <= fire & (state == HDR) & ~acc;
    end
  end

endmodule
